// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - write-back arbiter bus bundle (pipeline, long-latency, hazard, register-file sides)
interface wb_arbiter_if #(
   parameter int PTR_W   = 2,
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5
);
   logic               pipe_we;
   logic [RADDR_W-1:0] pipe_waddr;
   logic [DATA_W-1:0]  pipe_wdata;
   logic               lu_valid;
   logic               lu_ready;
   logic [RADDR_W-1:0] lu_waddr;
   logic [DATA_W-1:0]  lu_wdata;
   logic [RADDR_W-1:0] raddr1;
   logic [RADDR_W-1:0] raddr2;
   logic               pend1;
   logic               pend2;
   logic               wb_we;
   logic [RADDR_W-1:0] wb_waddr;
   logic [DATA_W-1:0]  wb_wdata;
   logic [PTR_W:0]     q_cnt;

   modport slave (
      input  pipe_we, pipe_waddr, pipe_wdata,
      input  lu_valid, lu_waddr, lu_wdata,
      input  raddr1, raddr2,
      output lu_ready, pend1, pend2,
      output wb_we, wb_waddr, wb_wdata, q_cnt
   );

   modport master (
      output pipe_we, pipe_waddr, pipe_wdata,
      output lu_valid, lu_waddr, lu_wdata,
      output raddr1, raddr2,
      input  lu_ready, pend1, pend2,
      input  wb_we, wb_waddr, wb_wdata, q_cnt
   );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter; optional queue bypass under WB_BYPASS_EN
module wb_arbiter #(
   parameter int DEPTH   = 4,
   parameter int PTR_W   = 2,
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5
) (
   input  logic clk,
   input  logic rst,
   wb_arbiter_if.slave bus
);
   localparam logic [PTR_W:0] LP_FULL = (PTR_W+1)'(DEPTH);

   logic [RADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0]  r_data [DEPTH];
   logic [DEPTH-1:0]   r_vld;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W:0]     r_cnt;
   logic               r_wb_we;
   logic [RADDR_W-1:0] r_wb_waddr;
   logic [DATA_W-1:0]  r_wb_wdata;

   logic w_pipe_eff;
   logic w_lu_ready;
   logic w_lu_xfer;
   logic w_bypass;
   logic w_push;
   logic w_pop;
   logic w_pend1;
   logic w_pend2;

   assign w_pipe_eff = bus.pipe_we && (bus.pipe_waddr != '0);
   assign w_lu_ready = (r_cnt != LP_FULL);
   assign w_lu_xfer  = bus.lu_valid && w_lu_ready;

`ifdef WB_BYPASS_EN
   // An idle write port with nothing queued lets a fresh result skip the queue.
   assign w_bypass = w_lu_xfer && (bus.lu_waddr != '0) && !w_pipe_eff && (r_cnt == '0);
`else
   assign w_bypass = 1'b0;
`endif

   // Writes to r0 are accepted but never stored.
   assign w_push = w_lu_xfer && (bus.lu_waddr != '0) && !w_bypass;
   assign w_pop  = !w_pipe_eff && (r_cnt != '0);

   // Hazard lookup against live queued entries only; killed entries do not stall decode.
   always_comb begin
      w_pend1 = 1'b0;
      w_pend2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_vld[i] && (r_addr[i] == bus.raddr1)) w_pend1 = 1'b1;
         if (r_vld[i] && (r_addr[i] == bus.raddr2)) w_pend2 = 1'b1;
      end
      if (bus.raddr1 == '0) w_pend1 = 1'b0;
      if (bus.raddr2 == '0) w_pend2 = 1'b0;
   end

   // Queue bookkeeping: WAW kill first, then pop, then push so a same-cycle push survives the kill.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_pipe_eff && (r_addr[i] == bus.pipe_waddr)) r_vld[i] <= 1'b0;
         end
         if (w_pop) begin
            r_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr        <= r_rd_ptr + 1'b1;
         end
         if (w_push) begin
            r_vld[r_wr_ptr] <= 1'b1;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Entry payload storage; validity lives in r_vld so no reset is needed here.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wr_ptr] <= bus.lu_waddr;
         r_data[r_wr_ptr] <= bus.lu_wdata;
      end
   end

   // Write-port register: pipeline wins, otherwise drain the head (killed head writes nothing).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wb_we    <= 1'b0;
         r_wb_waddr <= '0;
         r_wb_wdata <= '0;
      end else if (w_pipe_eff) begin
         r_wb_we    <= 1'b1;
         r_wb_waddr <= bus.pipe_waddr;
         r_wb_wdata <= bus.pipe_wdata;
      end else if (w_pop) begin
         r_wb_we    <= r_vld[r_rd_ptr];
         r_wb_waddr <= r_addr[r_rd_ptr];
         r_wb_wdata <= r_data[r_rd_ptr];
      end else if (w_bypass) begin
         r_wb_we    <= 1'b1;
         r_wb_waddr <= bus.lu_waddr;
         r_wb_wdata <= bus.lu_wdata;
      end else begin
         r_wb_we    <= 1'b0;
      end
   end

   assign bus.lu_ready = w_lu_ready;
   assign bus.pend1    = w_pend1;
   assign bus.pend2    = w_pend2;
   assign bus.wb_we    = r_wb_we;
   assign bus.wb_waddr = r_wb_waddr;
   assign bus.wb_wdata = r_wb_wdata;
   assign bus.q_cnt    = r_cnt;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter
module tb_wb_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      int          c;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;

   wb_arbiter_if #(.PTR_W(2), .DATA_W(32), .RADDR_W(5)) bus ();

   wb_arbiter #(.DEPTH(4), .PTR_W(2), .DATA_W(32), .RADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every register-file write must match the oldest expected write, in the expected cycle.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.wb_we) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL wb_unexpected got addr=%0d data=%h cyc=%0d expected no write",
                        bus.wb_waddr, bus.wb_wdata, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               if (bus.wb_waddr !== mon_e.a || bus.wb_wdata !== mon_e.d || cyc != mon_e.c) begin
                  errors++;
                  $display("FAIL wb_write got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                           bus.wb_waddr, bus.wb_wdata, cyc, mon_e.a, mon_e.d, mon_e.c);
               end
            end
         end else if (exp_q.size() != 0 && exp_q[0].c <= cyc) begin
            checks++;
            errors++;
            mon_e = exp_q.pop_front();
            $display("FAIL wb_missing got wb_we=0 cyc=%0d expected addr=%0d data=%h cyc=%0d",
                     cyc, mon_e.a, mon_e.d, mon_e.c);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, act, expv);
      end
   endtask

   task automatic expw(input int a, input int d, input int lat);
      wr_t e;
      e.a = 5'(a);
      e.d = 32'(d);
      e.c = cyc + lat;
      exp_q.push_back(e);
   endtask

   task automatic drive(input int pwe, input int pa, input int pd,
                        input int lv, input int la, input int ld);
      bus.pipe_we    = (pwe != 0);
      bus.pipe_waddr = 5'(pa);
      bus.pipe_wdata = 32'(pd);
      bus.lu_valid   = (lv != 0);
      bus.lu_waddr   = 5'(la);
      bus.lu_wdata   = 32'(ld);
   endtask

   initial begin
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      bus.raddr1 = '0;
      bus.raddr2 = '0;
      tick();
      tick();
      chk("rst_wb_we",    32'(bus.wb_we),    0);
      chk("rst_wb_waddr", 32'(bus.wb_waddr), 0);
      chk("rst_wb_wdata", bus.wb_wdata,      0);
      chk("rst_q_cnt",    32'(bus.q_cnt),    0);
      chk("rst_lu_ready", 32'(bus.lu_ready), 1);
      rst = 1'b1;
      tick();

      // Pipeline priority over queued long-latency results
      drive(1, 5, 'h11, 1, 7, 'h22); expw(5, 'h11, 1); tick();
      chk("prio_q_cnt1", 32'(bus.q_cnt), 1);
      drive(1, 5, 'h11, 1, 8, 'h33); expw(5, 'h11, 1); tick();
      chk("prio_q_cnt2", 32'(bus.q_cnt), 2);
      bus.raddr2 = 5'd8;
      drive(0, 0, 0, 0, 0, 0); expw(7, 'h22, 1);
      #1 chk("prio_pend2_set", 32'(bus.pend2), 1);
      tick();
      chk("prio_q_cnt_drain1", 32'(bus.q_cnt), 1);
      expw(8, 'h33, 1); tick();
      chk("prio_q_cnt_drain2", 32'(bus.q_cnt), 0);
      chk("prio_pend2_clear", 32'(bus.pend2), 0);
      bus.raddr2 = '0;
      tick();

      // Fill to full, hold a fifth result until a drain frees a slot
      for (int i = 0; i < 4; i++) begin
         drive(1, 5, 'h40 + i, 1, 10 + i, 'h100 + i); expw(5, 'h40 + i, 1); tick();
      end
      chk("full_q_cnt",    32'(bus.q_cnt),    4);
      chk("full_lu_ready", 32'(bus.lu_ready), 0);
      drive(1, 5, 'h50, 1, 14, 'h1E); expw(5, 'h50, 1); tick();
      chk("full_hold_q_cnt", 32'(bus.q_cnt), 4);
      drive(0, 0, 0, 1, 14, 'h1E); expw(10, 'h100, 1);
      #1 chk("full_pop_lu_ready", 32'(bus.lu_ready), 0);
      tick();
      chk("full_after_pop_q_cnt", 32'(bus.q_cnt),    3);
      chk("full_after_pop_ready", 32'(bus.lu_ready), 1);
      expw(11, 'h101, 1); tick();
      chk("full_push_pop_q_cnt", 32'(bus.q_cnt), 3);
      drive(0, 0, 0, 0, 0, 0);
      expw(12, 'h102, 1); tick();
      expw(13, 'h103, 1); tick();
      expw(14, 'h1E, 1);  tick();
      chk("full_drained_q_cnt", 32'(bus.q_cnt), 0);
      tick();

      // WAW kill: newer pipeline write to r3 voids the queued r3 result
      drive(1, 6, 'h66, 1, 3, 'hAA); expw(6, 'h66, 1); tick();
      bus.raddr1 = 5'd3;
      drive(1, 6, 'h67, 0, 0, 0); expw(6, 'h67, 1);
      #1 chk("waw_pend1_queued", 32'(bus.pend1), 1);
      tick();
      drive(1, 3, 'hBB, 0, 0, 0); expw(3, 'hBB, 1);
      #1 chk("waw_pend1_before_kill", 32'(bus.pend1), 1);
      tick();
      chk("waw_pend1_after_kill", 32'(bus.pend1), 0);
      chk("waw_q_cnt_killed",     32'(bus.q_cnt), 1);
      drive(0, 0, 0, 0, 0, 0); tick();
      chk("waw_q_cnt_popped", 32'(bus.q_cnt), 0);
      tick();

      // Address zero on both sources and on the hazard port
      bus.raddr1 = '0;
      drive(0, 0, 0, 1, 0, 'hDEAD); tick();
      chk("az_lu_q_cnt", 32'(bus.q_cnt), 0);
      drive(1, 0, 'hBEEF, 0, 0, 0); tick();
      drive(1, 5, 'h12, 1, 4, 'h44); expw(5, 'h12, 1); tick();
      bus.raddr2 = 5'd4;
      drive(1, 5, 'h13, 1, 0, 'h55); expw(5, 'h13, 1);
      #1 chk("az_pend1_zero", 32'(bus.pend1), 0);
      chk("az_pend2_r4", 32'(bus.pend2), 1);
      tick();
      chk("az_push_zero_q_cnt", 32'(bus.q_cnt), 1);
      drive(0, 0, 0, 0, 0, 0); expw(4, 'h44, 1); tick();
      bus.raddr2 = '0;
      tick();
      chk("az_q_cnt_empty", 32'(bus.q_cnt), 0);

      // Latency from handshake into an idle, empty arbiter
      drive(0, 0, 0, 1, 9, 'h5);
`ifdef WB_BYPASS_EN
      expw(9, 'h5, 1);
      tick();
      chk("byp_q_cnt", 32'(bus.q_cnt), 0);
`else
      expw(9, 'h5, 2);
      tick();
      chk("byp_q_cnt", 32'(bus.q_cnt), 1);
`endif
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      tick();

      // Asynchronous reset with entries queued
      for (int i = 0; i < 3; i++) begin
         drive(1, 5, 'h20 + i, 1, 20 + i, 'h200 + i); expw(5, 'h20 + i, 1); tick();
      end
      chk("rstm_q_cnt_before", 32'(bus.q_cnt), 3);
      rst = 1'b0;
      exp_q.delete();
      #1;
      chk("rstm_wb_we",    32'(bus.wb_we),    0);
      chk("rstm_q_cnt",    32'(bus.q_cnt),    0);
      chk("rstm_lu_ready", 32'(bus.lu_ready), 1);
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("rstm_q_cnt_after", 32'(bus.q_cnt), 0);

      tick();
      chk("exp_queue_empty", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter in front of the register file's single write port.
- Merges two write sources: the in-order pipeline write-back (never stalled) and results from long-latency units (divider, multi-cycle multiply) over a valid/ready handshake.
- Buffers long-latency results in a small queue and drains them into idle write-port cycles.
- Enforces write-after-write ordering and flags pending-write hazards to the decode stage.

Parameters:
- DEPTH, 4, queue entries (power of two, >=2)
- PTR_W, 2, log2(DEPTH)
- DATA_W, 32, register data width
- RADDR_W, 5, register address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset; 0 clears all state immediately
- pipe_we  in  1  pipeline write-back request
- pipe_waddr  in  RADDR_W  pipeline destination register
- pipe_wdata  in  DATA_W  pipeline write data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  arbiter can accept a long-latency result
- lu_waddr  in  RADDR_W  long-latency destination register
- lu_wdata  in  DATA_W  long-latency result data
- raddr1  in  RADDR_W  decode read address 1 (hazard check)
- raddr2  in  RADDR_W  decode read address 2 (hazard check)
- pend1  out  1  raddr1 has a pending queued write
- pend2  out  1  raddr2 has a pending queued write
- wb_we  out  1  register file write enable
- wb_waddr  out  RADDR_W  register file write address
- wb_wdata  out  DATA_W  register file write data
- q_cnt  out  PTR_W+1  number of occupied queue entries

Behaviour:
Reset
- rst=0: wb_we=0, wb_waddr=0, wb_wdata=0.
- Queue empty: q_cnt=0, read/write pointers 0, all entry-valid bits 0.
- Queued data is discarded if reset is asserted mid-operation.

Pipeline priority
- An effective pipeline write is pipe_we=1 and pipe_waddr!=0.
- It is registered to wb_we/wb_waddr/wb_wdata on the next edge (1-cycle latency).
- A write with pipe_waddr=0 is dropped: wb_we=0 for that cycle unless the queue drains.

Long-latency handshake
- lu_ready = (q_cnt != DEPTH), decoded from registered state only.
- A transfer occurs when lu_valid & lu_ready.
- lu_waddr=0: accepted and discarded, not enqueued.
- Otherwise the entry {valid=1, addr, data} is written at wr_ptr and wr_ptr increments modulo DEPTH.
- lu_waddr/lu_wdata must hold while lu_valid=1 and lu_ready=0.

Drain
- Applies in a cycle with no effective pipeline write and q_cnt>0: pop the head entry.
- If the head is valid, register it to wb_* (wb_we=1) on the next edge.
- If the head is killed, pop it with wb_we=0.
- At most one pop per cycle. Push and pop may occur in the same cycle; q_cnt then holds.

WAW kill
- An effective pipeline write to address X clears the valid bit of every queued entry whose addr==X. The pipeline result is newer.
- An entry pushed in the same cycle with addr X is NOT killed; it is treated as newer than the pipeline write.
- A killed entry still occupies its slot until popped.

Hazard flags
- Combinational.
- pendN = 1 iff raddrN!=0 and some queued entry is valid with addr==raddrN.
- Entries in flight in the wb_* register are not flagged; the register file forwards same-cycle writes.

Boundaries
- Full: lu_ready=0, even if a pop occurs that cycle.
- Pointers wrap at DEPTH.
- Queue empty and no pipeline write: wb_we=0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the queue is empty and there is no effective pipeline write, an accepted long-latency result with addr!=0 bypasses the queue. It goes directly to wb_* on the next edge and is not enqueued (1-cycle latency).
- Undefined: every long-latency result is enqueued; minimum latency from handshake to wb_we is 2 cycles.

Test Plan:
- Reset: drive rst=0 mid-stream with 3 entries queued -> wb_we=0, q_cnt=0, lu_ready=1 immediately. After release, no stale write appears.
- Priority: pipe_we=1 to r5=0x11 every cycle while lu pushes r7=0x22 -> only r5 writes. q_cnt=1, then 2 (no pops). On pipe_we=0, next cycle wb_we=1, waddr=7, wdata=0x22.
- Full: 4 lu pushes with pipe busy -> q_cnt=4, lu_ready=0. A 5th lu_valid is held until one drain cycle; data arrives intact afterwards.
- WAW kill: queue r3=0xAA, then pipe write r3=0xBB -> wb writes r3=0xBB. The later pop of r3 produces wb_we=0. pend1 with raddr1=3 goes 1 -> 0 at the kill.
- Address zero: lu push with waddr=0 -> q_cnt unchanged, no write. pipe write to r0 -> wb_we=0. raddr1=0 -> pend1=0.
- Bypass: empty queue, pipe idle, lu push r9=0x5 -> with WB_BYPASS_EN, wb_we=1 on the next edge. Without it, wb_we=1 two edges later.
